// File: rtl/boot_img_loader.sv
// rtl/boot_img_loader.sv - length-prefixed byte-stream image loader into boot image RAM
// Optional trailing checksum stage enabled by defining BOOT_IMG_CSUM_EN.
module boot_img_loader #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          done,
  output logic          err
);

  localparam logic [31:0] MAX_BYTES = 32'(4 * ((1 << AW) - 1));
  localparam int CW = AW + 2;

  typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR, S_HALT} state_t;

`ifdef BOOT_IMG_CSUM_EN
  localparam state_t S_AFTER     = S_CSUM;
  localparam logic   AFTER_READY = 1'b1;
`else
  localparam state_t S_AFTER     = S_DONE;
  localparam logic   AFTER_READY = 1'b0;
`endif

  state_t        state;
  logic [1:0]    lane;
  logic [31:0]   asm_q;
  logic [31:0]   asm_nx;
  logic [CW-1:0] len;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] bcnt_nx;
  logic [AW-1:0] widx;
  logic [AW-1:0] widx_nx;
  logic          accept;
`ifdef BOOT_IMG_CSUM_EN
  logic [31:0]   sum;
`endif

  assign accept  = in_valid & in_ready;
  assign bcnt_nx = bcnt + CW'(1);
  assign widx_nx = widx + AW'(1);

  // Assembler is cleared after every word, so a short final word is zero-padded.
  always_comb begin
    asm_nx = asm_q;
    asm_nx[8*lane +: 8] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HDR;
      in_ready  <= 1'b1;
      mem_cs    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      lane      <= '0;
      asm_q     <= '0;
      len       <= '0;
      bcnt      <= '0;
      widx      <= '0;
`ifdef BOOT_IMG_CSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_cs <= 1'b0;
      // Rearm wins over a byte handshake in the same cycle; that byte is dropped.
      if (start && (state == S_DONE || state == S_ERR || state == S_HALT)) begin
        state    <= S_HDR;
        in_ready <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        lane     <= '0;
        asm_q    <= '0;
        len      <= '0;
        bcnt     <= '0;
        widx     <= '0;
`ifdef BOOT_IMG_CSUM_EN
        sum      <= '0;
`endif
      end else begin
        case (state)
          S_HDR: if (accept) begin
            if (lane == 2'd3) begin
              lane  <= '0;
              asm_q <= '0;
              if (asm_nx > MAX_BYTES) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else begin
                mem_cs    <= 1'b1;
                mem_addr  <= '0;
                mem_wdata <= asm_nx;
                len       <= asm_nx[CW-1:0];
                if (asm_nx == 32'd0) begin
                  state    <= S_AFTER;
                  in_ready <= AFTER_READY;
                end else begin
                  state <= S_DATA;
                end
              end
            end else begin
              lane  <= lane + 2'd1;
              asm_q <= asm_nx;
            end
          end

          S_DATA: if (accept) begin
            bcnt <= bcnt_nx;
            if (lane == 2'd3 || bcnt_nx == len) begin
              mem_cs    <= 1'b1;
              mem_addr  <= widx_nx;
              mem_wdata <= asm_nx;
              widx      <= widx_nx;
              lane      <= '0;
              asm_q     <= '0;
`ifdef BOOT_IMG_CSUM_EN
              sum       <= sum + asm_nx;
`endif
              if (bcnt_nx == len) begin
                state    <= S_AFTER;
                in_ready <= AFTER_READY;
              end
            end else begin
              lane  <= lane + 2'd1;
              asm_q <= asm_nx;
            end
          end

`ifdef BOOT_IMG_CSUM_EN
          S_CSUM: if (accept) begin
            if (lane == 2'd3) begin
              lane     <= '0;
              asm_q    <= '0;
              in_ready <= 1'b0;
              if (asm_nx == sum) begin
                state <= S_DONE;
              end else begin
                state <= S_HALT;
                err   <= 1'b1;
              end
            end else begin
              lane  <= lane + 2'd1;
              asm_q <= asm_nx;
            end
          end
`endif

          S_DONE: done <= 1'b1;

          default: ;
        endcase
      end
    end
  end

endmodule
